// File: rtl/nn_f0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_f0_pkg : shared geometry constants and index helpers for nn_f0     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package nn_f0_pkg;

    localparam int IMG_DIM  = 12;
    localparam int K        = 3;
    localparam int POOL_DIM = 5;
    localparam int PIX_W    = 2;
    localparam int RES_W    = 5;
    localparam int MAP_W    = 128;

    localparam int CONV_DIM = IMG_DIM - K + 1;
    // Nine 2b x 2b products peak at 81, which needs 7 bits.
    localparam int SUM_W    = 7;
    localparam int IMG_BITS = IMG_DIM * IMG_DIM * PIX_W;
    localparam int KER_BITS = K * K * PIX_W;
    localparam int RES_MAX  = (1 << RES_W) - 1;

    function automatic int pix_idx(input int r, input int c);
        return IMG_DIM * r + c;
    endfunction

    function automatic int map_lsb(input int i, input int j);
        return RES_W * (POOL_DIM * i + j);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_f0_conv_pool.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_f0_conv_pool : one-kernel 3x3 valid conv, 2x2 max-pool, 5b clamp   |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module nn_f0_conv_pool
    import nn_f0_pkg::*;
(
    input  logic [IMG_BITS-1:0] img,
    input  logic [KER_BITS-1:0] kernel,
    output logic [MAP_W-1:0]    map
);

    logic [CONV_DIM*CONV_DIM*SUM_W-1:0] w_conv;

    for (genvar r = 0; r < CONV_DIM; r++) begin : g_row
        for (genvar c = 0; c < CONV_DIM; c++) begin : g_col
            logic [SUM_W-1:0] w_sum;

            // Correlation order: weight (dr,dc) meets pixel (r+dr, c+dc).
            always_comb begin
                w_sum = '0;
                for (int dr = 0; dr < K; dr++) begin
                    for (int dc = 0; dc < K; dc++) begin
                        w_sum = w_sum
                              + SUM_W'(img[PIX_W*pix_idx(r+dr, c+dc) +: PIX_W])
                              * SUM_W'(kernel[PIX_W*(K*dr+dc) +: PIX_W]);
                    end
                end
            end

            assign w_conv[SUM_W*(CONV_DIM*r+c) +: SUM_W] = w_sum;
        end
    end

    for (genvar i = 0; i < POOL_DIM; i++) begin : g_prow
        for (genvar j = 0; j < POOL_DIM; j++) begin : g_pcol
            logic [SUM_W-1:0] w_a, w_b, w_c, w_d;
            logic [SUM_W-1:0] w_top, w_bot, w_max;

            assign w_a   = w_conv[SUM_W*(CONV_DIM*(2*i)   + 2*j)   +: SUM_W];
            assign w_b   = w_conv[SUM_W*(CONV_DIM*(2*i)   + 2*j+1) +: SUM_W];
            assign w_c   = w_conv[SUM_W*(CONV_DIM*(2*i+1) + 2*j)   +: SUM_W];
            assign w_d   = w_conv[SUM_W*(CONV_DIM*(2*i+1) + 2*j+1) +: SUM_W];
            assign w_top = (w_a > w_b) ? w_a : w_b;
            assign w_bot = (w_c > w_d) ? w_c : w_d;
            assign w_max = (w_top > w_bot) ? w_top : w_bot;

            assign map[map_lsb(i, j) +: RES_W] =
                (w_max > SUM_W'(RES_MAX)) ? RES_W'(RES_MAX) : w_max[RES_W-1:0];
        end
    end

    assign map[MAP_W-1:POOL_DIM*POOL_DIM*RES_W] = '0;

endmodule
`default_nettype wire

// File: rtl/nn_f0.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_f0    : first CNN layer, four kernels, two-stage registered pipe   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module nn_f0
    import nn_f0_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IMG_BITS-1:0]   in,
    input  logic [KER_BITS-1:0]   filter1,
    input  logic [KER_BITS-1:0]   filter2,
    input  logic [KER_BITS-1:0]   filter3,
    input  logic [KER_BITS-1:0]   filter4,
    output logic [2*MAP_W-1:0]    out1,
    output logic [2*MAP_W-1:0]    out2
);

    localparam int NUM_FILT = 4;

    logic [IMG_BITS-1:0]               r_img;
    logic [NUM_FILT-1:0][KER_BITS-1:0] r_filt;
    logic [NUM_FILT-1:0][MAP_W-1:0]    w_map;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_img  <= '0;
            r_filt <= '0;
        end else begin
            r_img  <= in;
            r_filt <= {filter4, filter3, filter2, filter1};
        end
    end

    for (genvar f = 0; f < NUM_FILT; f++) begin : g_kernel
        nn_f0_conv_pool u_conv_pool (
            .img    (r_img),
            .kernel (r_filt[f]),
            .map    (w_map[f])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1 <= '0;
            out2 <= '0;
        end else begin
            out1 <= {w_map[1], w_map[0]};
            out2 <= {w_map[3], w_map[2]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_f0.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nn_f0 : scoreboard bench for nn_f0 against a direct conv/pool model|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nn_f0;

    typedef struct packed {
        logic [255:0] o1;
        logic [255:0] o2;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [287:0] img = '0;
    logic [17:0]  f1 = '0, f2 = '0, f3 = '0, f4 = '0;
    logic [255:0] out1, out2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    nn_f0 dut (
        .clk     (clk),
        .rst     (rst),
        .in      (img),
        .filter1 (f1),
        .filter2 (f2),
        .filter3 (f3),
        .filter4 (f4),
        .out1    (out1),
        .out2    (out2)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ref_map(input logic [287:0] im, input logic [17:0] k);
        logic [127:0] m;
        int conv [10][10];
        int s, v;
        m = '0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                s = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        s += int'(im[2*(12*(r+dr)+c+dc) +: 2]) * int'(k[2*(3*dr+dc) +: 2]);
                conv[r][c] = s;
            end
        end
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                v = conv[2*i][2*j];
                if (conv[2*i][2*j+1]   > v) v = conv[2*i][2*j+1];
                if (conv[2*i+1][2*j]   > v) v = conv[2*i+1][2*j];
                if (conv[2*i+1][2*j+1] > v) v = conv[2*i+1][2*j+1];
                if (v > 31) v = 31;
                m[5*(5*i+j) +: 5] = 5'(v);
            end
        end
        return m;
    endfunction

    task automatic drive_frame(input logic [287:0] im, input logic [17:0] a,
                               input logic [17:0] b, input logic [17:0] c, input logic [17:0] d);
        exp_t e;
        img = im; f1 = a; f2 = b; f3 = c; f4 = d;
        e.o1 = {ref_map(im, b), ref_map(im, a)};
        e.o2 = {ref_map(im, d), ref_map(im, c)};
        sb.push_back(e);
    endtask

    function automatic logic [287:0] rand_img();
        logic [287:0] v;
        for (int w = 0; w < 9; w++) v[32*w +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [287:0] std_img();
        logic [287:0] v;
        logic [27:0]  head;
        head = 28'b1000_101100001011_001101001011;
        v = '0;
        for (int p = 0; p < 144; p++) begin
            if (p < 28) v[2*p +: 2] = {1'b0, head[p]};
            else        v[2*p +: 2] = ((p * 7) % 5 < 2) ? 2'd1 : 2'd0;
        end
        return v;
    endfunction

    task automatic test_reset();
        exp_t e;
        #1;
        checks++;
        if (out1 !== '0 || out2 !== '0) begin
            errors++;
            $display("FAIL reset_state out1=%h out2=%h required 0", out1, out2);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_frame({144{2'b11}}, {9{2'b11}}, {9{2'b11}}, {9{2'b10}}, {9{2'b01}});
        @(negedge clk);
        checks++;
        if (out1 !== '0 || out2 !== '0) begin
            errors++;
            $display("FAIL release_first_edge out1=%h out2=%h required 0", out1, out2);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out1 !== e.o1 || out2 !== e.o2) begin
            errors++;
            $display("FAIL release_second_edge out1=%h out2=%h exp1=%h exp2=%h", out1, out2, e.o1, e.o2);
        end
        // Put a different frame in flight, then reset between edges.
        drive_frame(rand_img(), 18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()));
        void'(sb.pop_front());
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out1 !== '0 || out2 !== '0) begin
            errors++;
            $display("FAIL async_reset out1=%h out2=%h required 0", out1, out2);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out1 !== '0 || out2 !== '0) begin
            errors++;
            $display("FAIL reset_held out1=%h out2=%h required 0", out1, out2);
        end
        rst = 1'b0;
        drive_frame(img, f1, f2, f3, f4);
        @(negedge clk);
        checks++;
        if (out1 !== '0 || out2 !== '0) begin
            errors++;
            $display("FAIL rerelease_first_edge out1=%h out2=%h required 0", out1, out2);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out1 !== e.o1 || out2 !== e.o2) begin
            errors++;
            $display("FAIL rerelease_second_edge out1=%h out2=%h exp1=%h exp2=%h", out1, out2, e.o1, e.o2);
        end
    endtask

    task automatic test_zero();
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                e = sb.pop_front();
                checks++;
                if (out1 !== '0 || out2 !== '0 || e.o1 !== '0 || e.o2 !== '0) begin
                    errors++;
                    $display("FAIL zero_frame%0d out1=%h out2=%h required 0", n-2, out1, out2);
                end
            end
            if (n < 3)
                drive_frame('0, 18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()));
            else if (n < 6)
                drive_frame(rand_img(), '0, '0, '0, '0);
        end
    endtask

    task automatic test_impulse();
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                e = sb.pop_front();
                checks++;
                if (out1 !== e.o1 || out2 !== e.o2) begin
                    errors++;
                    $display("FAIL impulse_map out1=%h out2=%h exp1=%h exp2=%h", out1, out2, e.o1, e.o2);
                end
                checks++;
                if (out1[4:0] !== 5'd1 || out1[132:128] !== 5'd1) begin
                    errors++;
                    $display("FAIL impulse_res00 map1=%0d map2=%0d required 1 and 1", out1[4:0], out1[132:128]);
                end
            end
            if (n < 2) drive_frame(std_img(), 18'h00100, 18'h00004, 18'h04000, 18'h00400);
        end
    endtask

    task automatic test_constant(input string name, input logic [287:0] im,
                                 input logic [17:0] w, input logic [4:0] val);
        exp_t e;
        logic [127:0] half;
        half = {3'b0, {25{val}}};
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                e = sb.pop_front();
                checks++;
                if (out1 !== {half, half} || out2 !== {half, half} || e.o1 !== {half, half}) begin
                    errors++;
                    $display("FAIL %s out1=%h out2=%h required half=%h", name, out1, out2, half);
                end
            end
            if (n < 2) drive_frame(im, w, w, w, w);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                e = sb.pop_front();
                checks++;
                if (out1 !== e.o1 || out2 !== e.o2) begin
                    errors++;
                    $display("FAIL b2b_frame%0d out1=%h out2=%h exp1=%h exp2=%h", n-2, out1, out2, e.o1, e.o2);
                end
            end
            if (n < 12)
                drive_frame(rand_img(), 18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()));
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_impulse();
        test_constant("saturate", {144{2'b11}}, {9{2'b11}}, 5'd31);
        test_constant("no_clamp27", {144{2'b01}}, {9{2'b11}}, 5'd27);
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
